// File: rtl/mdu_iter_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   - op encodings (identical to RV32M funct3)
//   - FSM state encoding
//   - iteration count
//   - operand signedness helpers
package mdu_iter_pkg;

   localparam int MDU_ITER = 32;

   localparam logic [2:0] MDU_MUL    = 3'b000;
   localparam logic [2:0] MDU_MULH   = 3'b001;
   localparam logic [2:0] MDU_MULHSU = 3'b010;
   localparam logic [2:0] MDU_MULHU  = 3'b011;
   localparam logic [2:0] MDU_DIV    = 3'b100;
   localparam logic [2:0] MDU_DIVU   = 3'b101;
   localparam logic [2:0] MDU_REM    = 3'b110;
   localparam logic [2:0] MDU_REMU   = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIN  = 2'd2
   } state_t;

   function automatic logic src0_signed(input logic [2:0] op);
      logic s;
      case (op)
         MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM: s = 1'b1;
         default:                                s = 1'b0;
      endcase
      return s;
   endfunction

   function automatic logic src1_signed(input logic [2:0] op);
      logic s;
      case (op)
         MDU_MULH, MDU_DIV, MDU_REM: s = 1'b1;
         default:                    s = 1'b0;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/mdu_div_core.sv
// One restoring-division step, purely combinational.
//   rem_in   : current partial remainder (always < divisor, so WIDTH bits suffice)
//   dvd_bit  : next dividend bit shifted in
//   divisor  : divisor magnitude
//   rem_out  : updated partial remainder
//   q_bit    : quotient bit produced by this step
// The trial subtraction is carried out on WIDTH+1 bits so that the shifted
// remainder, which can reach 2*divisor-1, never overflows.
module mdu_div_core #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic             dvd_bit,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_out,
   output logic             q_bit
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   assign shifted = {rem_in, dvd_bit};
   assign diff    = shifted - {1'b0, divisor};
   assign q_bit   = ~diff[WIDTH];
   assign rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit sitting between the register file read
// ports and writeback. Multiplies by shift-add and divides by restoring
// division, one bit per cycle over 32 cycles, on operand magnitudes. The sign
// is fixed up when the result is captured.
//
// Ports:
//   clk, rst         clock; asynchronous active-high reset
//   start            request, sampled only while busy=0
//   op               RV32M funct3
//   src0, src1       rs1 / rs2 operand values
//   wa_in            destination register
//   flush            abort the in-flight operation; no result is produced
//   busy             operation in flight
//   done, res_we     one-cycle result-valid pulse
//   res, res_wa      result and its destination, held until the next result
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; outputs hold the last result
// CALC  | 32 shift-add or restoring-divide iterations
// FIN   | res/res_wa were captured on entry; done/res_we high
module mdu_iter
   import mdu_iter_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] src0,
   input  logic [WIDTH-1:0] src1,
   input  logic [4:0]       wa_in,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] res,
   output logic [4:0]       res_wa,
   output logic             res_we
);

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [2:0]         op_q;
   logic [4:0]         wa_q;
   logic [WIDTH-1:0]   mag1;
   logic               neg_main;
   logic               neg_rem;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   rem;

   // Operand magnitudes and sign flags at acceptance.
   logic             s0_neg, s1_neg;
   logic [WIDTH-1:0] abs0, abs1;

   assign s0_neg = src0_signed(op) & src0[WIDTH-1];
   assign s1_neg = src1_signed(op) & src1[WIDTH-1];
   assign abs0   = s0_neg ? (~src0 + 1'b1) : src0;
   assign abs1   = s1_neg ? (~src1 + 1'b1) : src1;

   // Special cases complete without iterating.
   logic             is_div, div_zero, div_ovf, special;
   logic [WIDTH-1:0] special_res;

   assign is_div   = op[2];
   assign div_zero = is_div && (src1 == '0);
   assign div_ovf  = ((op == MDU_DIV) || (op == MDU_REM)) &&
                     (src0 == {1'b1, {(WIDTH-1){1'b0}}}) && (src1 == '1);
   assign special  = div_zero || div_ovf;

   // op[1] separates REM/REMU from DIV/DIVU.
   always_comb begin
      special_res = '0;
      if (div_zero)
         special_res = op[1] ? src0 : '1;
      else
         special_res = op[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
   end

   // Multiply step: multiplier sits in the low half, partial sum in the high half.
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] prod_nxt;

   assign mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (prod[0] ? mag1 : '0)};
   assign prod_nxt = {mul_sum, prod[WIDTH-1:1]};

   // Divide step: dividend shifts out of quo MSB-first, quotient bits shift in.
   logic [WIDTH-1:0] rem_nxt, quo_nxt;
   logic             q_bit;

   mdu_div_core #(.WIDTH(WIDTH)) u_div_core (
      .rem_in  (rem),
      .dvd_bit (quo[WIDTH-1]),
      .divisor (mag1),
      .rem_out (rem_nxt),
      .q_bit   (q_bit)
   );

   assign quo_nxt = {quo[WIDTH-2:0], q_bit};

   // Final result, formed from the last iteration's next-state values.
   logic [2*WIDTH-1:0] mul_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix, final_res;

   assign mul_fix = neg_main ? (~prod_nxt + 1'b1) : prod_nxt;
   assign quo_fix = neg_main ? (~quo_nxt + 1'b1) : quo_nxt;
   assign rem_fix = neg_rem  ? (~rem_nxt + 1'b1) : rem_nxt;

   always_comb begin
      final_res = '0;
      case (op_q)
         MDU_MUL:                        final_res = mul_fix[WIDTH-1:0];
         MDU_MULH, MDU_MULHSU, MDU_MULHU: final_res = mul_fix[2*WIDTH-1:WIDTH];
         MDU_DIV, MDU_DIVU:              final_res = quo_fix;
         default:                        final_res = rem_fix;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         op_q     <= '0;
         wa_q     <= '0;
         mag1     <= '0;
         neg_main <= 1'b0;
         neg_rem  <= 1'b0;
         prod     <= '0;
         quo      <= '0;
         rem      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         res      <= '0;
         res_wa   <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start && !flush) begin
                  op_q     <= op;
                  wa_q     <= wa_in;
                  mag1     <= abs1;
                  neg_main <= s0_neg ^ s1_neg;
                  neg_rem  <= s0_neg;
                  prod     <= {{WIDTH{1'b0}}, abs0};
                  quo      <= abs0;
                  rem      <= '0;
                  cnt      <= CNT_W'(MDU_ITER - 1);
                  busy     <= 1'b1;
                  if (special) begin
                     res    <= special_res;
                     res_wa <= wa_in;
                     done   <= 1'b1;
                     state  <= ST_FIN;
                  end else begin
                     state  <= ST_CALC;
                  end
               end
            end
            ST_CALC: begin
               if (flush) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end else begin
                  prod <= prod_nxt;
                  quo  <= quo_nxt;
                  rem  <= rem_nxt;
                  cnt  <= cnt - 1'b1;
                  if (cnt == '0) begin
                     res    <= final_res;
                     res_wa <= wa_q;
                     done   <= 1'b1;
                     state  <= ST_FIN;
                  end
               end
            end
            ST_FIN: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign res_we = done;

endmodule

// File: tb/tb_mdu_iter.sv
module tb_mdu_iter;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  op;
   logic [31:0] src0;
   logic [31:0] src1;
   logic [4:0]  wa_in;
   logic        flush;
   logic        busy;
   logic        done;
   logic [31:0] res;
   logic [4:0]  res_wa;
   logic        res_we;

   int n_checks = 0;
   int n_errors = 0;

   mdu_iter #(.WIDTH(32), .CNT_W(5)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (op),
      .src0   (src0),
      .src1   (src1),
      .wa_in  (wa_in),
      .flush  (flush),
      .busy   (busy),
      .done   (done),
      .res    (res),
      .res_wa (res_wa),
      .res_we (res_we)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one operation, wait for done (bounded), check latency, busy span and result.
   task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] wa,
                         input logic [31:0] exp_res, input int exp_lat);
      int lat;
      int busy_cnt;
      lat      = 0;
      busy_cnt = 0;
      op    = o;
      src0  = a;
      src1  = b;
      wa_in = wa;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 1; i <= 60; i++) begin
         if (busy) busy_cnt++;
         if (done) begin
            lat = i;
            break;
         end
         tick();
      end
      check({tag, "_lat"},  32'(lat), 32'(exp_lat));
      check({tag, "_busy"}, 32'(busy_cnt), 32'(exp_lat));
      check({tag, "_res"},  res, exp_res);
      check({tag, "_wa"},   {27'd0, res_wa}, {27'd0, wa});
      check({tag, "_we"},   {31'd0, res_we}, 32'd1);
      tick();
      check({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
   endtask

   initial begin
      int ndone;
      int first_lat;
      logic [31:0] cap_res;
      logic [4:0]  cap_wa;

      rst   = 1'b1;
      start = 1'b0;
      flush = 1'b0;
      op    = 3'b000;
      src0  = 32'd0;
      src1  = 32'd0;
      wa_in = 5'd0;
      #12;
      check("rst_busy", {31'd0, busy},   32'd0);
      check("rst_done", {31'd0, done},   32'd0);
      check("rst_we",   {31'd0, res_we}, 32'd0);
      check("rst_res",  res,             32'd0);
      check("rst_wa",   {27'd0, res_wa}, 32'd0);
      rst = 1'b0;
      tick();

      // Iterative operations: done at c+33.
      run_op("mul",    3'b000, 32'd7,         32'd6,         5'd5,  32'd42,        33);
      run_op("mul_neg",3'b000, 32'hFFFF_FFFF, 32'd3,         5'd6,  32'hFFFF_FFFD, 33);
      run_op("mulh",   3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'h0000_0000, 33);
      run_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFE, 33);
      run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2,         5'd9,  32'hFFFF_FFFF, 33);
      run_op("div",    3'b100, 32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFD, 33);
      run_op("rem",    3'b110, 32'hFFFF_FFF9, 32'd2,         5'd11, 32'hFFFF_FFFF, 33);
      run_op("remu",   3'b111, 32'd100,       32'd7,         5'd12, 32'd2,         33);

      // Special cases: done at c+1.
      run_op("divu_z", 3'b101, 32'd5,         32'd0,         5'd13, 32'hFFFF_FFFF, 1);
      run_op("rem_z",  3'b110, 32'd5,         32'd0,         5'd14, 32'd5,         1);
      run_op("div_ov", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1);
      run_op("rem_ov", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0,         1);
      run_op("divu",   3'b101, 32'd100,       32'd7,         5'd17, 32'd14,        33);

      // Flush at CALC iteration 10: no done, outputs hold the DIVU result.
      op    = 3'b000;
      src0  = 32'h1234;
      src1  = 32'h55;
      wa_in = 5'd20;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (9) tick();
      check("fl_busy_pre", {31'd0, busy}, 32'd1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("fl_busy", {31'd0, busy}, 32'd0);
      check("fl_done", {31'd0, done}, 32'd0);
      check("fl_res",  res,             32'd14);
      check("fl_wa",   {27'd0, res_wa}, 32'd17);
      tick();
      check("fl_done2", {31'd0, done}, 32'd0);
      run_op("after_fl", 3'b000, 32'd7, 32'd6, 5'd5, 32'd42, 33);

      // flush wins over a simultaneous start.
      op    = 3'b101;
      src0  = 32'd9;
      src1  = 32'd3;
      wa_in = 5'd3;
      start = 1'b1;
      flush = 1'b1;
      tick();
      start = 1'b0;
      flush = 1'b0;
      check("fl_start_busy", {31'd0, busy}, 32'd0);
      check("fl_start_done", {31'd0, done}, 32'd0);

      // start while busy is ignored: exactly one done, first op's result.
      op    = 3'b000;
      src0  = 32'd7;
      src1  = 32'd6;
      wa_in = 5'd5;
      start = 1'b1;
      tick();
      start = 1'b0;
      ndone     = 0;
      first_lat = 0;
      cap_res   = 32'd0;
      cap_wa    = 5'd0;
      for (int i = 1; i <= 80; i++) begin
         if (done) begin
            ndone++;
            if (ndone == 1) begin
               first_lat = i;
               cap_res   = res;
               cap_wa    = res_wa;
            end
         end
         if (i == 4) begin
            op    = 3'b101;
            src0  = 32'd100;
            src1  = 32'd7;
            wa_in = 5'd9;
            start = 1'b1;
         end
         if (i == 5) start = 1'b0;
         tick();
      end
      check("sb_ndone", 32'(ndone),     32'd1);
      check("sb_lat",   32'(first_lat), 32'd33);
      check("sb_res",   cap_res,        32'd42);
      check("sb_wa",    {27'd0, cap_wa}, 32'd5);

      // Asynchronous reset mid-CALC clears outputs immediately.
      op    = 3'b001;
      src0  = 32'hFFFF_FFFF;
      src1  = 32'd3;
      wa_in = 5'd21;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      check("ar_busy_pre", {31'd0, busy}, 32'd1);
      #1;
      rst = 1'b1;
      #1;
      check("ar_busy", {31'd0, busy},   32'd0);
      check("ar_res",  res,             32'd0);
      check("ar_wa",   {27'd0, res_wa}, 32'd0);
      check("ar_done", {31'd0, done},   32'd0);
      #1;
      rst = 1'b0;
      tick();
      run_op("after_rst", 3'b111, 32'd100, 32'd7, 5'd22, 32'd2, 33);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
